// File: rtl/rf_wb_queue.sv
// Write-back queue in front of the 8x8 register file write port.
// It buffers execute-stage results, drains one per cycle, and offers a bypass lookup.
module rf_wb_queue #(
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_addr,
  input  logic [7:0]    in_data,
  input  logic          hold,
  output logic          regwrite,
  output logic [2:0]    wa,
  output logic [7:0]    wd,
  input  logic [2:0]    q_ra,
  output logic          q_hit,
  output logic [7:0]    q_data,
  output logic [PW:0]   count,
  output logic          empty,
  output logic          full
);

  localparam int DEPTH = 1 << PW;

  logic [2:0]    r_addr [DEPTH];
  logic [7:0]    r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          r_regwrite;
  logic [2:0]    r_wa;
  logic [7:0]    r_wd;

  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic          w_hit;
  logic [7:0]    w_data;
  logic [PW-1:0] w_idx;

  assign w_full  = (r_count == (PW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  // Writes to r0 are accepted but dropped; readiness depends on full alone.
  assign w_push  = in_valid && !w_full && (in_addr != 3'd0);
  assign w_pop   = !hold && !w_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= in_addr;
      r_data[r_tail] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_regwrite <= 1'b0;
      r_wa       <= '0;
      r_wd       <= '0;
    end else begin
      if (w_push)
        r_tail <= r_tail + PW'(1);
      if (w_pop)
        r_head <= r_head + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
      r_regwrite <= w_pop;
      if (w_pop) begin
        r_wa <= r_addr[r_head];
        r_wd <= r_data[r_head];
      end
    end
  end

  // Output stage is the oldest candidate; walking head->tail lets younger entries override.
  always_comb begin
    w_hit  = 1'b0;
    w_data = '0;
    w_idx  = '0;
    if (r_regwrite && (r_wa == q_ra)) begin
      w_hit  = 1'b1;
      w_data = r_wd;
    end
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PW'(i);
      if (((PW+1)'(i) < r_count) && (r_addr[w_idx] == q_ra)) begin
        w_hit  = 1'b1;
        w_data = r_data[w_idx];
      end
    end
    if (q_ra == 3'd0) begin
      w_hit  = 1'b0;
      w_data = '0;
    end
  end

  assign in_ready = !w_full;
  assign regwrite = r_regwrite;
  assign wa       = r_wa;
  assign wd       = r_wd;
  assign q_hit    = w_hit;
  assign q_data   = w_data;
  assign count    = r_count;
  assign empty    = w_empty;
  assign full     = w_full;

endmodule

// File: tb/tb_rf_wb_queue.sv
// Scoreboard bench for rf_wb_queue: a reference queue model predicts every
// register-file write, the occupancy flags and the bypass result each cycle.
module tb_rf_wb_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_addr;
  logic [7:0] in_data;
  logic       hold;
  logic       regwrite;
  logic [2:0] wa;
  logic [7:0] wd;
  logic [2:0] q_ra;
  logic       q_hit;
  logic [7:0] q_data;
  logic [2:0] count;
  logic       empty;
  logic       full;

  int checks   = 0;
  int failures = 0;

  logic [10:0] mQ[$];
  logic        mReg = 1'b0;
  logic [2:0]  mWa  = 3'd0;
  logic [7:0]  mWd  = 8'd0;
  logic        doPop;
  logic        doPush;
  logic [10:0] pend;
  logic        expHit;
  logic [7:0]  expData;

  rf_wb_queue #(.PW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_addr(in_addr), .in_data(in_data), .hold(hold),
    .regwrite(regwrite), .wa(wa), .wd(wd),
    .q_ra(q_ra), .q_hit(q_hit), .q_data(q_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] a, input logic [7:0] d, input logic h);
    in_valid = v;
    in_addr  = a;
    in_data  = d;
    hold     = h;
    @(negedge clk);
  endtask

  // Youngest queued write wins, then the output stage; r0 never hits.
  task automatic calcBypass();
    expHit  = 1'b0;
    expData = 8'd0;
    if (q_ra != 3'd0) begin
      if (mReg && mWa == q_ra) begin
        expHit  = 1'b1;
        expData = mWd;
      end
      foreach (mQ[i]) begin
        if (mQ[i][10:8] == q_ra) begin
          expHit  = 1'b1;
          expData = mQ[i][7:0];
        end
      end
    end
  endtask

  always @(posedge rst) begin
    mQ.delete();
    mReg = 1'b0;
    mWa  = 3'd0;
    mWd  = 8'd0;
  end

  always @(posedge clk) begin
    if (rst === 1'b0) begin
      doPop  = !hold && (mQ.size() > 0);
      doPush = in_valid && (mQ.size() < 4) && (in_addr != 3'd0);
      pend   = {in_addr, in_data};
      if (doPop) begin
        {mWa, mWd} = mQ.pop_front();
        mReg = 1'b1;
      end else begin
        mReg = 1'b0;
      end
      if (doPush)
        mQ.push_back(pend);
      #1;
      checkOutput("regwrite", 16'(regwrite), 16'(mReg));
      checkOutput("wa", 16'(wa), 16'(mWa));
      checkOutput("wd", 16'(wd), 16'(mWd));
      checkOutput("count", 16'(count), 16'(mQ.size()));
      checkOutput("in_ready", 16'(in_ready), 16'(mQ.size() < 4));
      checkOutput("empty", 16'(empty), 16'(mQ.size() == 0));
      checkOutput("full", 16'(full), 16'(mQ.size() == 4));
      calcBypass();
      checkOutput("q_hit", 16'(q_hit), 16'(expHit));
      checkOutput("q_data", 16'(q_data), 16'(expData));
    end
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_addr  = 3'd0;
    in_data  = 8'd0;
    hold     = 1'b0;
    q_ra     = 3'd3;
    #3;
    checkOutput("rst_regwrite", 16'(regwrite), 16'd0);
    checkOutput("rst_count", 16'(count), 16'd0);
    checkOutput("rst_in_ready", 16'(in_ready), 16'd1);
    checkOutput("rst_empty", 16'(empty), 16'd1);
    @(negedge clk);
    rst = 1'b0;

    // Single write latency
    applyStimulus(1'b1, 3'd3, 8'h5A, 1'b0);
    repeat (3) applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);

    // Fill under hold, fifth write stalls until a slot frees
    q_ra = 3'd4;
    for (int k = 1; k <= 5; k++)
      applyStimulus(1'b1, 3'(k), 8'(k * 8'h11), 1'b1);
    applyStimulus(1'b1, 3'd5, 8'h55, 1'b1);
    applyStimulus(1'b1, 3'd5, 8'h55, 1'b0);
    applyStimulus(1'b1, 3'd5, 8'h55, 1'b0);
    repeat (6) applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);

    // Writes to r0 are dropped; r0 lookup never hits
    q_ra = 3'd0;
    applyStimulus(1'b1, 3'd0, 8'hFF, 1'b0);
    repeat (2) applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);

    // Same-register writes: bypass returns the youngest
    q_ra = 3'd6;
    applyStimulus(1'b1, 3'd6, 8'h10, 1'b1);
    applyStimulus(1'b1, 3'd6, 8'h20, 1'b1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b1);
    checkOutput("byp_youngest", 16'(q_data), 16'h20);
    repeat (2) applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
    checkOutput("byp_outstage_hit", 16'(q_hit), 16'd1);
    checkOutput("byp_outstage_data", 16'(q_data), 16'h20);
    repeat (2) applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);

    // Back-to-back pushes wrap the pointers
    q_ra = 3'd2;
    for (int k = 0; k < 10; k++)
      applyStimulus(1'b1, 3'((k % 7) + 1), 8'(k), 1'b0);
    repeat (3) applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);

    // Async reset with entries queued and the output stage busy
    for (int k = 1; k <= 4; k++)
      applyStimulus(1'b1, 3'(k), 8'(8'hA0 + k), 1'b1);
    applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_regwrite", 16'(regwrite), 16'd0);
    checkOutput("async_wa", 16'(wa), 16'd0);
    checkOutput("async_wd", 16'(wd), 16'd0);
    checkOutput("async_count", 16'(count), 16'd0);
    checkOutput("async_in_ready", 16'(in_ready), 16'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) applyStimulus(1'b0, 3'd0, 8'h00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rf_wb_queue.md
# rf_wb_queue

Write-back queue feeding the 8 x 8-bit register file's single write port. It accepts result writes from the execute stage over a valid/ready handshake and buffers them in a DEPTH-entry FIFO. It drains one write per cycle into the register file as registered regwrite/wa/wd. It also exposes a bypass lookup so operand fetch can see values that are queued but not yet committed.

## Interface
- PW, 2, pointer width; DEPTH = 1<<PW entries (default 4)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- in_valid  in  1  execute stage presents a write
- in_ready  out  1  queue can accept; = !full
- in_addr  in  3  destination register
- in_data  in  8  result value
- hold  in  1  when 1, no pop this cycle
- regwrite  out  1  register-file write enable (registered)
- wa  out  3  register-file write address (registered)
- wd  out  8  register-file write data (registered)
- q_ra  in  3  bypass lookup address
- q_hit  out  1  q_ra has a pending write
- q_data  out  8  youngest pending value for q_ra
- count  out  PW+1  entries held, 0..DEPTH
- empty  out  1  count == 0
- full  out  1  count == DEPTH

## Operation
- Push: in_valid && in_ready at a rising edge. If in_addr == 0, the write is consumed and discarded: no enqueue, count unchanged. Otherwise {in_addr, in_data} is written at the tail, and the tail advances modulo DEPTH.
- in_ready depends only on full. A pop in the same cycle does not free a slot for a push when full.
- Pop: at each edge, if !hold && !empty, the head entry is popped into the output register. regwrite <= 1, wa <= head addr, wd <= head data, and the head advances modulo DEPTH.
- Otherwise regwrite <= 0, and wa/wd hold their previous values.
- Simultaneous push and pop when not full: both occur, and count is unchanged.
- Order is strict FIFO. Multiple pending writes to the same register all commit in order.
- Bypass is combinational.
  - Candidates are the valid queue entries, plus the output stage while regwrite == 1. The output stage's write is not yet in the register file.
  - Priority: youngest queue entry (nearest tail) first, then the output stage.
  - q_ra == 0 gives q_hit = 0 and q_data = 0. No hit gives q_data = 0.
- Pointers are PW bits and wrap. count is a separate PW+1-bit counter; full/empty derive from count.

## Timing
- Reset (async assert, any time) clears the pointers, count, regwrite, wa and wd to 0. All pending writes are discarded mid-operation with no partial commit. in_ready = 1 and empty = 1 while reset is asserted and after release.
- Latency: a push at edge N into an empty queue with hold = 0 pops at edge N+1. regwrite = 1 from edge N+1 to N+2, and the register file commits at edge N+2.
- No same-cycle flow-through: an entry pushed at edge N is never popped at edge N.
- Throughput: one write per cycle, sustained.
- hold held high: the queue fills. in_ready drops the cycle after count reaches DEPTH and rises the cycle after the first pop.
- q_hit/q_data reflect state after the most recent edge. The same-cycle incoming in_data is not bypassed.

## Test plan
- Reset then push (addr 3, 0x5A): edge N+1 gives regwrite = 1, wa = 3, wd = 0x5A. Edge N+2 gives regwrite = 0, count = 0.
- hold = 1 while pushing (1,0x11), (2,0x22), (3,0x33), (4,0x44), (5,0x55): the first four enqueue and count = 4, full = 1, in_ready = 0. The fifth stalls. Release hold: writes emerge in order 0x11..0x44 on consecutive cycles, then 0x55.
- Push (0, 0xFF) while empty: no enqueue, count stays 0, regwrite never asserts. Lookup q_ra = 0 gives q_hit = 0.
- hold = 1, push (6,0x10) then (6,0x20): q_ra = 6 gives q_hit = 1, q_data = 0x20. Release hold: 0x10 commits, then 0x20. While 0x20 is in the output stage with the queue empty, the lookup still gives q_hit = 1, q_data = 0x20.
- Pointer wrap: 10 back-to-back pushes (addr k%7+1, data k) with hold = 0. regwrite is continuous from the second edge, and data sequence 0..9 comes out in order.
- Assert rst asynchronously with 3 entries queued and regwrite = 1: outputs go 0 immediately, count = 0, and no further writes follow after release.
